traffic_ctrl_2way: RTL and testbench



---
 rtl/traffic_ctrl_2way.sv | 191 +++++++++++++++++++
 tb/tb_traffic_ctrl_2way.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_ctrl_2way.sv
// traffic_ctrl_2way: two-direction intersection controller with
// green/yellow/all-red phases, pedestrian request, night flash mode.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   night_en  level, requests flashing-yellow night mode
//   ped_req   pedestrian request pulse, latched internally
//   ns_led    NS head, one-hot: 001 red, 010 green, 100 yellow, 000 dark
//   ew_led    EW head, same encoding
//   remain    whole seconds left in the current phase (0 in FLASH)
//   phase     current state code, for debug
module traffic_ctrl_2way #(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned GREEN_S     = 20,
    parameter int unsigned YELLOW_S    = 3,
    parameter int unsigned ALLRED_S    = 1,
    parameter int unsigned MIN_GREEN_S = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       night_en,
    input  logic       ped_req,
    output logic [2:0] ns_led,
    output logic [2:0] ew_led,
    output logic [7:0] remain,
    output logic [2:0] phase
);

    localparam int unsigned PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_FREQ - 1);

    localparam logic [7:0] G_D      = 8'(GREEN_S);
    localparam logic [7:0] Y_D      = 8'(YELLOW_S);
    localparam logic [7:0] AR_D     = 8'(ALLRED_S);
    localparam logic [7:0] G_LAST   = 8'(GREEN_S - 1);
    localparam logic [7:0] Y_LAST   = 8'(YELLOW_S - 1);
    localparam logic [7:0] AR_LAST  = 8'(ALLRED_S - 1);
    localparam logic [7:0] MIN_LAST = 8'(MIN_GREEN_S - 1);

    localparam logic [2:0] RED  = 3'b001;
    localparam logic [2:0] GRN  = 3'b010;
    localparam logic [2:0] YEL  = 3'b100;
    localparam logic [2:0] DARK = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_AR1   = 3'd1,
        S_NS_G  = 3'd2,
        S_NS_Y  = 3'd3,
        S_AR2   = 3'd4,
        S_EW_G  = 3'd5,
        S_EW_Y  = 3'd6,
        S_FLASH = 3'd7
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    sec_q, sec_d;
    logic          ped_q, ped_d;
    logic          flash_q, flash_d;
    logic [2:0]    ns_q, ns_d;
    logic [2:0]    ew_q, ew_d;
    logic [7:0]    remain_q, remain_d;
    logic [2:0]    phase_q, phase_d;

    logic tick;
    logic changed;
    logic green_end;
    logic ar_end;
    logic y_end;

    assign tick   = (pre_q == PRE_LAST);
    assign ar_end = tick && (sec_q == AR_LAST);
    assign y_end  = tick && (sec_q == Y_LAST);

    // Night mode cuts green at the next tick; a pending pedestrian
    // request cuts it once the minimum green has been served.
    assign green_end = tick && ((sec_q == G_LAST) || night_en ||
                                (ped_q && (sec_q >= MIN_LAST)));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = S_AR1;
            S_AR1:   if (ar_end) state_d = night_en ? S_FLASH : S_NS_G;
            S_NS_G:  if (green_end) state_d = S_NS_Y;
            S_NS_Y:  if (y_end) state_d = S_AR2;
            S_AR2:   if (ar_end) state_d = night_en ? S_FLASH : S_EW_G;
            S_EW_G:  if (green_end) state_d = S_EW_Y;
            S_EW_Y:  if (y_end) state_d = S_AR1;
            S_FLASH: if (tick && !night_en) state_d = S_AR1;
            default: state_d = S_IDLE;
        endcase
    end

    assign changed = (state_d != state_q);

    // Timing restarts on every state change so each phase is an
    // exact multiple of the second.
    always_comb begin
        pre_d = pre_q + 1'b1;
        sec_d = sec_q;
        if (changed) begin
            pre_d = '0;
            sec_d = '0;
        end else if (tick) begin
            pre_d = '0;
            if (state_q != S_FLASH) sec_d = sec_q + 8'd1;
        end
    end

    // A request coinciding with yellow entry is kept for the next green.
    always_comb begin
        ped_d = ped_q;
        if (changed && (state_d == S_NS_Y || state_d == S_EW_Y))
            ped_d = 1'b0;
        if (ped_req) ped_d = 1'b1;
    end

    // Flash starts lit and toggles once per second.
    always_comb begin
        flash_d = flash_q;
        if (changed && state_d == S_FLASH)
            flash_d = 1'b1;
        else if (state_q == S_FLASH && tick)
            flash_d = ~flash_q;
    end

    always_comb begin
        ns_d     = RED;
        ew_d     = RED;
        remain_d = '0;
        phase_d  = state_q;
        unique case (state_q)
            S_AR1, S_AR2: remain_d = AR_D - sec_q;
            S_NS_G: begin
                ns_d     = GRN;
                remain_d = G_D - sec_q;
            end
            S_NS_Y: begin
                ns_d     = YEL;
                remain_d = Y_D - sec_q;
            end
            S_EW_G: begin
                ew_d     = GRN;
                remain_d = G_D - sec_q;
            end
            S_EW_Y: begin
                ew_d     = YEL;
                remain_d = Y_D - sec_q;
            end
            S_FLASH: begin
                ns_d = flash_q ? YEL : DARK;
                ew_d = flash_q ? YEL : DARK;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pre_q    <= '0;
            sec_q    <= '0;
            ped_q    <= 1'b0;
            flash_q  <= 1'b0;
            ns_q     <= RED;
            ew_q     <= RED;
            remain_q <= '0;
            phase_q  <= '0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            sec_q    <= sec_d;
            ped_q    <= ped_d;
            flash_q  <= flash_d;
            ns_q     <= ns_d;
            ew_q     <= ew_d;
            remain_q <= remain_d;
            phase_q  <= phase_d;
        end
    end

    assign ns_led = ns_q;
    assign ew_led = ew_q;
    assign remain = remain_q;
    assign phase  = phase_q;

endmodule

// File: tb/tb_traffic_ctrl_2way.sv
// tb_traffic_ctrl_2way: directed phase-length scenarios plus random
// ped/night/reset traffic checked cycle by cycle against a timing model.
module tb_traffic_ctrl_2way;

    localparam int CF = 10;
    localparam int G  = 5;
    localparam int Y  = 2;
    localparam int AR = 1;
    localparam int MG = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       night_en = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] ns_led;
    logic [2:0] ew_led;
    logic [7:0] remain;
    logic [2:0] phase;

    int n_chk  = 0;
    int n_fail = 0;

    // model: phase code, cycles spent in it, latched request
    int mst  = 0;
    int mcyc = 0;
    bit mped = 1'b0;

    traffic_ctrl_2way #(
        .CLK_FREQ   (CF),
        .GREEN_S    (G),
        .YELLOW_S   (Y),
        .ALLRED_S   (AR),
        .MIN_GREEN_S(MG)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .night_en(night_en),
        .ped_req (ped_req),
        .ns_led  (ns_led),
        .ew_led  (ew_led),
        .remain  (remain),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [16:0] model_out();
        int s = mcyc / CF;
        logic [2:0] ns = 3'b001;
        logic [2:0] ew = 3'b001;
        int rem = 0;
        case (mst)
            1, 4: rem = AR - s;
            2: begin ns = 3'b010; rem = G - s; end
            3: begin ns = 3'b100; rem = Y - s; end
            5: begin ew = 3'b010; rem = G - s; end
            6: begin ew = 3'b100; rem = Y - s; end
            7: begin
                ns = ((s % 2) == 0) ? 3'b100 : 3'b000;
                ew = ns;
            end
            default: ;
        endcase
        return {ns, ew, 8'(rem), 3'(mst)};
    endfunction

    task automatic model_step(input bit nt, input bit pd);
        int s = mcyc / CF;
        bit tk = (mcyc % CF) == CF - 1;
        bit gend;
        int nx = mst;
        gend = tk && (s == G - 1 || nt || (mped && s >= MG - 1));
        case (mst)
            0: nx = 1;
            1: if (tk && s == AR - 1) nx = nt ? 7 : 2;
            2: if (gend) nx = 3;
            3: if (tk && s == Y - 1) nx = 4;
            4: if (tk && s == AR - 1) nx = nt ? 7 : 5;
            5: if (gend) nx = 6;
            6: if (tk && s == Y - 1) nx = 1;
            7: if (tk && !nt) nx = 1;
            default: nx = 0;
        endcase
        if (nx != mst && (nx == 3 || nx == 6)) mped = 1'b0;
        if (pd) mped = 1'b1;
        mcyc = (nx != mst) ? 0 : mcyc + 1;
        mst  = nx;
    endtask

    task automatic cycle(input bit nt, input bit pd, input bit r);
        logic [16:0] e;
        logic bad;
        night_en = nt;
        ped_req  = pd;
        rst      = r;
        @(posedge clk);
        if (r) begin
            e    = {3'b001, 3'b001, 8'd0, 3'd0};
            mst  = 0;
            mcyc = 0;
            mped = 1'b0;
        end else begin
            e = model_out();
            model_step(nt, pd);
        end
        #1;
        chk("out", {15'd0, ns_led, ew_led, remain, phase}, {15'd0, e});
        bad = (ns_led == 3'b010 && (ew_led == 3'b010 || ew_led == 3'b100)) ||
              (ew_led == 3'b010 && (ns_led == 3'b010 || ns_led == 3'b100));
        chk("safe", {31'd0, bad}, 32'd0);
    endtask

    task automatic run_until(input int ph, input bit nt);
        int n = 0;
        while (int'(phase) != ph && n < 1000) begin
            cycle(nt, 1'b0, 1'b0);
            n++;
        end
        chk("reach", {29'd0, phase}, ph);
    endtask

    // Length in cycles of the phase currently displayed; night is held
    // from index nfrom on, ped pulses at index pat.
    task automatic seg(input int nfrom, input int pat, output int len);
        int ph = int'(phase);
        int n = 1;
        while (int'(phase) == ph && n < 1000) begin
            cycle(n >= nfrom, n == pat, 1'b0);
            n++;
        end
        len = n - 1;
    endtask

    initial begin
        int l;
        int per;
        int n;
        bit nt;

        // reset held, then released
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        chk("rst_ns", {29'd0, ns_led}, 32'h1);
        chk("rst_ew", {29'd0, ew_led}, 32'h1);
        chk("rst_rem", {24'd0, remain}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("rel1_phase", {29'd0, phase}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("rel2_phase", {29'd0, phase}, 32'd1);
        chk("rel2_rem", {24'd0, remain}, AR);

        // normal cycle
        per = 0;
        seg(1000, -1, l); chk("ar1_len", l, 10); per += l;
        chk("nsg_rem0", {24'd0, remain}, G);
        seg(1000, -1, l); chk("nsg_len", l, 50); per += l;
        seg(1000, -1, l); chk("nsy_len", l, 20); per += l;
        seg(1000, -1, l); chk("ar2_len", l, 10); per += l;
        seg(1000, -1, l); chk("ewg_len", l, 50); per += l;
        seg(1000, -1, l); chk("ewy_len", l, 20); per += l;
        chk("period", per, 160);

        // pedestrian, early
        run_until(2, 1'b0);
        seg(1000, 3, l); chk("ped_early_nsg", l, 20);
        chk("ped_early_next", {29'd0, phase}, 32'd3);
        run_until(5, 1'b0);
        seg(1000, -1, l); chk("ped_early_ewg", l, 50);

        // pedestrian, late, and a request latched during yellow
        run_until(5, 1'b0);
        seg(1000, 30, l); chk("ped_late_ewg", l, 40);
        run_until(3, 1'b0);
        seg(1000, 2, l); chk("ped_y_nsy", l, 20);
        run_until(5, 1'b0);
        seg(1000, -1, l); chk("ped_y_ewg", l, 20);

        // night entry and exit
        run_until(2, 1'b0);
        seg(25, -1, l); chk("night_nsg", l, 30);
        seg(0, -1, l); chk("night_nsy", l, 20);
        seg(0, -1, l); chk("night_ar2", l, 10);
        run_until(7, 1'b1);
        chk("flash_ns", {29'd0, ns_led}, 32'h4);
        chk("flash_ew", {29'd0, ew_led}, 32'h4);
        chk("flash_rem", {24'd0, remain}, 32'd0);
        n = 1;
        while (ns_led == 3'b100 && n < 100) begin
            cycle(1'b1, 1'b0, 1'b0);
            n++;
        end
        chk("flash_lit", n - 1, 10);
        n = 1;
        while (ns_led == 3'b000 && n < 100) begin
            cycle(1'b1, 1'b0, 1'b0);
            n++;
        end
        chk("flash_dark", n - 1, 10);
        run_until(1, 1'b0);
        seg(1000, -1, l); chk("night_exit_ar1", l, 10);
        chk("night_exit_nsg", {29'd0, phase}, 32'd2);

        // reset during EW_Y with a pending request
        run_until(6, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        chk("mid_rst_ns", {29'd0, ns_led}, 32'h1);
        chk("mid_rst_ew", {29'd0, ew_led}, 32'h1);
        chk("mid_rst_phase", {29'd0, phase}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("mid_rst_ar1", {29'd0, phase}, 32'd1);
        seg(1000, -1, l); chk("mid_rst_ar1_len", l, 10);
        seg(1000, -1, l); chk("mid_rst_nsg_len", l, 50);

        // random ped/night/reset traffic
        nt = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(399) == 0) nt = ~nt;
            cycle(nt, $urandom_range(24) == 0, $urandom_range(3999) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
